// File: rtl/axi_scrub_pkg.sv
// rtl/axi_scrub_pkg.sv - shared types, constants and burst-length helper for the memory scrubber
package axi_scrub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scrub_state_e;

  typedef enum logic [1:0] {
    MODE_ZERO    = 2'd0,
    MODE_PATTERN = 2'd1,
    MODE_ADDR    = 2'd2,
    MODE_RSVD    = 2'd3
  } scrub_mode_e;

  localparam int unsigned AXI_BURST_BYTES_MAX = 4096;
  localparam logic [1:0]  BRESP_OKAY          = 2'b00;

  // Burst length (beats - 1) limited by the burst cap, the bytes left in the
  // range and the distance to the next 4KB boundary. Caller guarantees cur < end.
  function automatic logic [7:0] calc_awlen(input logic [63:0] cur,
                                            input logic [63:0] end_addr,
                                            input int unsigned max_beats,
                                            input int unsigned bytes_per_beat);
    logic [63:0] rem_beats;
    logic [63:0] bnd_beats;
    logic [63:0] beats;
    rem_beats = (end_addr - cur) / 64'(bytes_per_beat);
    bnd_beats = (64'(AXI_BURST_BYTES_MAX) - {52'd0, cur[11:0]}) / 64'(bytes_per_beat);
    beats     = 64'(max_beats);
    if (rem_beats < beats) beats = rem_beats;
    if (bnd_beats < beats) beats = bnd_beats;
    return 8'(beats - 64'd1);
  endfunction

endpackage

// File: rtl/axi_mem_scrubber_if.sv
// rtl/axi_mem_scrubber_if.sv - AXI4 write-channel bundle (AW, W, B) with master/slave views
// Ports: master drives AW/W and bready; slave drives awready, wready and the B channel.
interface axi_mem_scrubber_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 16
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_scrub_pattern_gen.sv
// rtl/axi_scrub_pattern_gen.sv - combinational fill-data generator for one write beat
// Ports: mode (fill mode), pattern (32-bit fill word), beat_addr (byte address of the beat),
//        data (full-width beat payload).
module axi_scrub_pattern_gen
  import axi_scrub_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic [1:0]            mode,
  input  logic [31:0]           pattern,
  input  logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int LANES = DATA_WIDTH / 64;

  always_comb begin
    data = '0;
    case (mode)
      MODE_PATTERN: data = {(DATA_WIDTH/32){pattern}};
      MODE_ADDR: begin
        // each 64-bit lane carries its own byte address
        for (int i = 0; i < LANES; i++) begin
          data[i*64 +: 64] = 64'(beat_addr) + 64'(8 * i);
        end
      end
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/axi_mem_scrubber.sv
// rtl/axi_mem_scrubber.sv - write-only AXI4 master that fills an address range with a pattern
// Ports: clk/rst; cfg_* (range, mode, pattern); scrb_enable run request;
//        scrb_addr/scrb_state/scrb_done/scrb_err status; axi (AXI4 write master).
module axi_mem_scrubber
  import axi_scrub_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int ID_WIDTH        = 16,
  parameter int AXI_ID          = 0,
  parameter int BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
  input  logic [1:0]            cfg_mode,
  input  logic [31:0]           cfg_pattern,
  input  logic                  scrb_enable,
  output logic [ADDR_WIDTH-1:0] scrb_addr,
  output logic [2:0]            scrb_state,
  output logic                  scrb_done,
  output logic                  scrb_err,
  axi_mem_scrubber_if.master    axi
);
  localparam int BPB   = DATA_WIDTH / 8;
  localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_ADDR  = ST_ADDR;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [7:0]            beat_cnt;
  logic [OST_W-1:0]      outstanding;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  b_dec;
  logic                  ost_avail;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic [ADDR_WIDTH-1:0] next_cur;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [DATA_WIDTH-1:0] gen_data;
  logic                  unused_bid;

  assign axi.awid   = ID_WIDTH'(AXI_ID);
  assign axi.wid    = ID_WIDTH'(AXI_ID);
  assign axi.awsize = 3'($clog2(BPB));
  assign axi.wstrb  = '1;

  assign scrb_state = state;
  assign scrb_done  = (state == S_DONE);
  assign unused_bid = ^axi.bid;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign b_hs  = axi.bvalid && axi.bready;
  // a stray B with nothing outstanding must not underflow the counter
  assign b_dec = b_hs && (outstanding != '0);
  // a slot freed by a B in this cycle can be reused immediately
  assign ost_avail = (outstanding < OST_W'(MAX_OUTSTANDING)) || b_dec;

  assign burst_bytes = ADDR_WIDTH'({1'b0, axi.awlen} + 9'd1) * ADDR_WIDTH'(BPB);
  assign next_cur    = cur_addr + burst_bytes;

  // wdata is always loaded one beat ahead: first beat at the AW handshake,
  // the following beat on each non-final W handshake
  assign gen_addr = (state == S_ADDR) ? cur_addr : beat_addr + ADDR_WIDTH'(BPB);

  axi_scrub_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pattern_gen (
    .mode     (mode_q),
    .pattern  (cfg_pattern),
    .beat_addr(gen_addr),
    .data     (gen_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_dec})
        2'b10:   outstanding <= outstanding + OST_W'(1);
        2'b01:   outstanding <= outstanding - OST_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      end_q       <= '0;
      mode_q      <= '0;
      beat_addr   <= '0;
      beat_cnt    <= '0;
      scrb_addr   <= '0;
      scrb_err    <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awlen   <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wlast   <= 1'b0;
      axi.bready  <= 1'b0;
    end else begin
      axi.bready <= 1'b1;
      if (b_hs && (axi.bresp != BRESP_OKAY)) scrb_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (scrb_enable) begin
            cur_addr <= cfg_start_addr;
            end_q    <= cfg_end_addr;
            mode_q   <= cfg_mode;
            scrb_err <= 1'b0;
            state    <= (cfg_start_addr >= cfg_end_addr) ? S_DONE : S_ADDR;
          end
        end

        S_ADDR: begin
          if (aw_hs) begin
            scrb_addr   <= axi.awaddr;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b1;
            axi.wdata   <= gen_data;
            axi.wlast   <= (axi.awlen == 8'd0);
            beat_addr   <= cur_addr;
            beat_cnt    <= 8'd0;
            state       <= S_DATA;
          end else if (!axi.awvalid) begin
            // once awvalid is up the request is committed; abort only before it
            if (!scrb_enable) begin
              state <= S_DRAIN;
            end else if (ost_avail) begin
              axi.awvalid <= 1'b1;
              axi.awaddr  <= cur_addr;
              axi.awlen   <= calc_awlen(64'(cur_addr), 64'(end_q),
                                        BURST_LEN, BPB);
            end
          end
        end

        S_DATA: begin
          if (w_hs) begin
            if (axi.wlast) begin
              axi.wvalid <= 1'b0;
              axi.wlast  <= 1'b0;
              cur_addr   <= next_cur;
              state      <= ((next_cur == end_q) || !scrb_enable) ? S_DRAIN : S_ADDR;
            end else begin
              beat_cnt  <= beat_cnt + 8'd1;
              axi.wlast <= ((beat_cnt + 8'd1) == axi.awlen);
              beat_addr <= gen_addr;
              axi.wdata <= gen_data;
            end
          end
        end

        S_DRAIN: begin
          // cur_addr short of the end means the run was aborted
          if (outstanding == '0) state <= (cur_addr == end_q) ? S_DONE : S_IDLE;
        end

        S_DONE: begin
          if (!scrb_enable) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_scrubber.sv
// tb/tb_axi_mem_scrubber.sv - self-checking bench for axi_mem_scrubber
module tb_axi_mem_scrubber;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [AW-1:0] cfg_end_addr = '0;
  logic [1:0]    cfg_mode = '0;
  logic [31:0]   cfg_pattern = '0;
  logic          scrb_enable = 1'b0;
  logic [AW-1:0] scrb_addr;
  logic [2:0]    scrb_state;
  logic          scrb_done;
  logic          scrb_err;

  axi_mem_scrubber_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

  axi_mem_scrubber #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(0),
    .BURST_LEN(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern), .scrb_enable(scrb_enable),
    .scrb_addr(scrb_addr), .scrb_state(scrb_state), .scrb_done(scrb_done),
    .scrb_err(scrb_err), .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] start_a;
    logic [63:0] end_a;
    int          mode;
    logic [31:0] pat;
    int          bad_burst;
    bit          rand_rdy;
    int          exp_bursts;
    logic [63:0] f_addr;
    logic [7:0]  f_len;
    logic [63:0] l_addr;
    logic [7:0]  l_len;
    bit          exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_err = 0;

  // bench model state
  int          mode_g, bad_burst_g;
  logic [31:0] pat_g;
  logic [63:0] start_g, exp_w_addr;
  bit          rand_g, b_auto, done_seen, drain_seen;
  int          b_credit, pending_b;
  int          aw_cnt, w_cnt, b_cnt, w_bad, aw_bad, stab_bad, beat_in_burst;
  logic [7:0]  cur_len, first_len, last_len;
  logic [63:0] first_addr, last_addr, cap0, cap7;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int m, input logic [31:0] p, input logic [63:0] a);
    logic [DW-1:0] d;
    d = '0;
    if (m == 1) d = {16{p}};
    else if (m == 2) for (int i = 0; i < 8; i++) d[i*64 +: 64] = a + 64'(8 * i);
    return d;
  endfunction

  task automatic begin_run(input logic [63:0] s, input int m, input logic [31:0] p,
                           input int bad, input bit rr);
    start_g = s; exp_w_addr = s; mode_g = m; pat_g = p; bad_burst_g = bad; rand_g = rr;
    b_auto = 1'b1; b_credit = 0; pending_b = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; w_bad = 0; aw_bad = 0; stab_bad = 0;
    beat_in_burst = 0; done_seen = 0; drain_seen = 0;
    first_addr = '0; last_addr = '0; first_len = '0; last_len = '0; cur_len = '0;
  endtask

  // Records the handshakes the coming edge will take, advances one clock and
  // drives the slave-side inputs for the next edge.
  task automatic tick();
    bit aw_hold, w_hold;
    logic [63:0]   h_awaddr;
    logic [7:0]    h_awlen;
    logic [DW-1:0] h_wdata;
    logic          h_wlast;
    aw_hold  = (axi.awvalid === 1'b1) && (axi.awready === 1'b0);
    w_hold   = (axi.wvalid === 1'b1) && (axi.wready === 1'b0);
    h_awaddr = axi.awaddr; h_awlen = axi.awlen; h_wdata = axi.wdata; h_wlast = axi.wlast;
    if (axi.awvalid === 1'b1 && axi.awready === 1'b1) begin
      if (axi.awaddr !== start_g + 64'(64 * w_cnt)) aw_bad++;
      if (aw_cnt == 0) begin first_addr = axi.awaddr; first_len = axi.awlen; end
      last_addr = axi.awaddr; last_len = axi.awlen; cur_len = axi.awlen;
      aw_cnt++;
    end
    if (axi.wvalid === 1'b1 && axi.wready === 1'b1) begin
      if (axi.wdata !== exp_data(mode_g, pat_g, exp_w_addr)) w_bad++;
      if (axi.wlast !== (beat_in_burst == int'(cur_len))) w_bad++;
      if (mode_g == 2 && exp_w_addr == 64'h1040) begin
        cap0 = axi.wdata[63:0]; cap7 = axi.wdata[511:448];
      end
      if (axi.wlast === 1'b1) begin beat_in_burst = 0; pending_b++; end
      else beat_in_burst++;
      exp_w_addr += 64;
      w_cnt++;
    end
    if (axi.bvalid === 1'b1 && axi.bready === 1'b1) begin
      b_cnt++;
      if (pending_b > 0) pending_b--;
      if (!b_auto && b_credit > 0) b_credit--;
    end
    @(posedge clk);
    #1;
    if (aw_hold && (axi.awvalid !== 1'b1 || axi.awaddr !== h_awaddr || axi.awlen !== h_awlen)) stab_bad++;
    if (w_hold && (axi.wvalid !== 1'b1 || axi.wdata !== h_wdata || axi.wlast !== h_wlast)) stab_bad++;
    axi.bvalid = (pending_b > 0) && (b_auto || b_credit > 0);
    axi.bresp  = (b_cnt == bad_burst_g) ? 2'b10 : 2'b00;
    if (rand_g) begin
      axi.awready = 1'($urandom_range(0, 1));
      axi.wready  = 1'($urandom_range(0, 1));
    end else begin
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
    end
    if (scrb_done === 1'b1) done_seen = 1'b1;
    if (scrb_state === 3'd3) drain_seen = 1'b1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_awvalid"}, axi.awvalid, 0);
    check({p, "_awaddr"}, axi.awaddr, 0);
    check({p, "_awlen"}, axi.awlen, 0);
    check({p, "_awsize"}, axi.awsize, 6);
    check({p, "_awid"}, axi.awid, 0);
    check({p, "_wvalid"}, axi.wvalid, 0);
    check({p, "_wlast"}, axi.wlast, 0);
    check({p, "_wdata_zero"}, (axi.wdata == '0), 1);
    check({p, "_bready"}, axi.bready, 0);
    check({p, "_state"}, scrb_state, 0);
    check({p, "_done"}, scrb_done, 0);
    check({p, "_err"}, scrb_err, 0);
    check({p, "_scrb_addr"}, scrb_addr, 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int guard;
    int exp_beats;
    string n;
    n = $sformatf("v%0d", k);
    exp_beats = (v.end_a > v.start_a) ? int'((v.end_a - v.start_a) / 64) : 0;
    begin_run(v.start_a, v.mode, v.pat, v.bad_burst, v.rand_rdy);
    cfg_start_addr = v.start_a; cfg_end_addr = v.end_a;
    cfg_mode = 2'(v.mode); cfg_pattern = v.pat; scrb_enable = 1'b1;
    guard = 0;
    while (scrb_done !== 1'b1 && guard < 4000) begin tick(); guard++; end
    check({n, "_done_in_time"}, (guard < 4000), 1);
    check({n, "_state"}, scrb_state, 4);
    check({n, "_bursts"}, aw_cnt, v.exp_bursts);
    check({n, "_beats"}, w_cnt, exp_beats);
    check({n, "_bresps"}, b_cnt, v.exp_bursts);
    check({n, "_err"}, scrb_err, v.exp_err);
    check({n, "_wbeat_bad"}, w_bad, 0);
    check({n, "_awaddr_seq_bad"}, aw_bad, 0);
    check({n, "_stable_bad"}, stab_bad, 0);
    if (v.exp_bursts > 0) begin
      check({n, "_first_addr"}, first_addr, v.f_addr);
      check({n, "_first_len"}, first_len, v.f_len);
      check({n, "_last_addr"}, last_addr, v.l_addr);
      check({n, "_last_len"}, last_len, v.l_len);
      check({n, "_scrb_addr"}, scrb_addr, v.l_addr);
    end
    scrb_enable = 1'b0;
    tick(); tick();
    check({n, "_back_idle"}, scrb_state, 0);
    check({n, "_done_clear"}, scrb_done, 0);
  endtask

  initial begin
    int guard;
    vecs[0] = '{64'h0,    64'h10000, 1, 32'hDEADBEEF, -1, 1'b0, 16, 64'h0,    8'd63, 64'hF000, 8'd63, 1'b0};
    vecs[1] = '{64'h0FC0, 64'h1100,  2, 32'h0,        -1, 1'b0,  2, 64'h0FC0, 8'd0,  64'h1000, 8'd3,  1'b0};
    vecs[2] = '{64'h0,    64'h4000,  0, 32'h0,         1, 1'b0,  4, 64'h0,    8'd63, 64'h3000, 8'd63, 1'b1};
    vecs[3] = '{64'h2000, 64'h2000,  1, 32'h11111111, -1, 1'b0,  0, 64'h0,    8'd0,  64'h0,    8'd0,  1'b0};
    vecs[4] = '{64'h3000, 64'h2000,  2, 32'h0,        -1, 1'b0,  0, 64'h0,    8'd0,  64'h0,    8'd0,  1'b0};
    vecs[5] = '{64'h0100, 64'h0200,  3, 32'hFFFFFFFF, -1, 1'b0,  1, 64'h0100, 8'd3,  64'h0100, 8'd3,  1'b0};
    vecs[6] = '{64'h1F00, 64'h2300,  2, 32'h0,        -1, 1'b1,  2, 64'h1F00, 8'd3,  64'h2000, 8'd11, 1'b0};
    vecs[7] = '{64'h0,    64'h1000,  1, 32'h12345678,  0, 1'b1,  1, 64'h0,    8'd63, 64'h0,    8'd63, 1'b1};

    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    begin_run(64'h0, 0, 32'h0, -1, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    tick();
    check("por_bready_up", axi.bready, 1);
    check("por_wstrb", (axi.wstrb == '1), 1);

    for (int k = 0; k < NV; k++) run_vec(vecs[k], k);

    check("lane0_beat_1040", cap0, 64'h1040);
    check("lane7_beat_1040", cap7, 64'h1078);

    // outstanding limit: withhold B responses, then release one
    begin_run(64'h0, 0, 32'h0, -1, 1'b0);
    b_auto = 1'b0;
    cfg_start_addr = 64'h0; cfg_end_addr = 64'h10000; cfg_mode = 2'd0; scrb_enable = 1'b1;
    repeat (400) tick();
    check("ost_aw_count", aw_cnt, 4);
    check("ost_awvalid_low", axi.awvalid, 0);
    check("ost_state_addr", scrb_state, 1);
    b_credit = 1; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    guard = 0;
    while (aw_cnt < 5 && guard < 4) begin tick(); guard++; end
    check("ost_fifth_aw", aw_cnt, 5);
    check("ost_fifth_aw_latency_ok", (guard <= 2), 1);
    b_auto = 1'b1;
    guard = 0;
    while (scrb_done !== 1'b1 && guard < 3000) begin tick(); guard++; end
    check("ost_done", scrb_done, 1);
    check("ost_bursts", aw_cnt, 16);
    check("ost_wbeat_bad", w_bad, 0);
    scrb_enable = 1'b0;
    tick(); tick();

    // abort in the middle of burst 3
    begin_run(64'h0, 1, 32'hA5A5A5A5, -1, 1'b0);
    cfg_start_addr = 64'h0; cfg_end_addr = 64'h10000; cfg_mode = 2'd1; cfg_pattern = 32'hA5A5A5A5;
    scrb_enable = 1'b1;
    guard = 0;
    while (w_cnt < 160 && guard < 1000) begin tick(); guard++; end
    scrb_enable = 1'b0;
    drain_seen = 1'b0;
    guard = 0;
    while (scrb_state !== 3'd0 && guard < 500) begin tick(); guard++; end
    repeat (5) tick();
    check("abort_state_idle", scrb_state, 0);
    check("abort_aw_count", aw_cnt, 3);
    check("abort_beats", w_cnt, 192);
    check("abort_bresps", b_cnt, 3);
    check("abort_via_drain", drain_seen, 1);
    check("abort_never_done", done_seen, 0);
    check("abort_scrb_addr", scrb_addr, 64'h2000);
    check("abort_wbeat_bad", w_bad, 0);

    // reset in the middle of a data burst
    begin_run(64'h0, 2, 32'h0, -1, 1'b0);
    cfg_start_addr = 64'h0; cfg_end_addr = 64'h10000; cfg_mode = 2'd2; scrb_enable = 1'b1;
    guard = 0;
    while (w_cnt < 5 && guard < 100) begin tick(); guard++; end
    check("mid_in_data", scrb_state, 2);
    rst = 1'b1;
    tick();
    check_reset("mid");
    rst = 1'b0; scrb_enable = 1'b0;
    begin_run(64'h0, 0, 32'h0, -1, 1'b0);
    axi.bvalid = 1'b0;
    tick(); tick();
    check("mid_after_idle", scrb_state, 0);
    check("mid_after_awvalid", axi.awvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
